idexe_pipe_reg: RTL and testbench
=================================

// Module: idexe_pipe_reg
// PURPOSE
//  Parametrised ID/EX pipeline register for the 5-stage core. Adds hold (freeze) and flush (bubble)
//  control, a valid bit, and write-back snooping. While an instruction is held, a WB write to one of
//  its source registers patches the held operand. A saturating counter reports consecutive held cycles.
//  Sits between the ID stage (register file, control unit) and the EXE stage (ALU, branch unit).
// PARAMETERS
//  LEN     32  PC / instruction width
//  DATA_W  32  register-file data width (reg1, reg2, imm)
//  RADDR_W 5   register address width (src1, src2, dest, wb_dest)
//  CMD_W   4   ALU command width
//  CNT_W   4   stall counter width
// PORTS
//  clock            in   1        rising-edge clock
//  reset            in   1        asynchronous, active-high reset
//  freeze           in   1        hold all contents this cycle (hazard stall)
//  flush            in   1        replace contents with a bubble this cycle
//  valid_in         in   1        ID-stage instruction is valid
//  pc, instruction  in   LEN      ID-stage PC / instruction
//  wb_en, mem_read, mem_write in 1  control bits from the control unit
//  branch_type      in   2        00 none, 01 BEZ, 10 BNE, 11 JMP
//  exe_cmd          in   CMD_W    ALU command
//  src1, src2       in   RADDR_W  source register addresses
//  reg1, reg2       in   DATA_W   register-file read values
//  imm              in   DATA_W   sign-extended immediate
//  dest             in   RADDR_W  destination register
//  wb_wr_en         in   1        WB stage is writing the register file
//  wb_dest          in   RADDR_W  WB destination address
//  wb_value         in   DATA_W   WB write data
//  <each input>_out out  same     registered copy (pc_out ... dest_out, incl. src1_out/src2_out)
//  valid_out        out  1        EXE-stage instruction is valid
//  stall_cycles     out  CNT_W    consecutive freeze cycles on the current valid instruction
// BEHAVIOUR
//  - Reset (async, immediate): every output is 0. This includes valid_out, all control bits,
//    datapath fields and stall_cycles. reset has priority over everything.
//  - Per-edge priority: flush > freeze > load.
//  - Load (no flush, no freeze): all fields capture their inputs; latency is 1 cycle.
//    valid_out <= valid_in.
//    If valid_in=0, then wb_en_out, mem_read_out, mem_write_out and branch_type_out load 0.
//    stall_cycles <= 0.
//  - Write-through on load: if wb_wr_en=1, wb_dest!=0 and wb_dest==src1, reg1_out loads wb_value
//    instead of reg1. The same rule applies independently to src2/reg2. Both may match in one cycle.
//  - Flush: valid_out=0. wb_en/mem_read/mem_write/branch_type outputs are 0. All other fields load 0.
//    stall_cycles <= 0. A flush during freeze still bubbles, because flush wins.
//  - Freeze: all fields hold, except for WB snooping.
//    If valid_out=1, wb_wr_en=1, wb_dest!=0 and wb_dest==src1_out, reg1_out <= wb_value.
//    The same rule applies to reg2_out. No snooping when valid_out=0.
//  - stall_cycles: during freeze with valid_out=1, increments by 1 and saturates at 2^CNT_W-1
//    (never wraps). During freeze with valid_out=0 it holds.
//  - Register 0 is never snooped or written through (hard-wired zero).
//  - No combinational path from any input to any output.
// TESTING
//  1. Reset mid-stream: assert reset asynchronously between edges with valid_out=1
//     -> all outputs 0 immediately, before the next edge.
//  2. Load: valid_in=1, pc=0x40, exe_cmd=4'h1, reg1=5, reg2=7, dest=3
//     -> next cycle the _out fields match and valid_out=1.
//  3. Freeze with snoop: held src1_out=4, reg1_out=0x11; freeze=1, wb_wr_en=1, wb_dest=4,
//     wb_value=0xAB -> reg1_out=0xAB. All other fields unchanged. stall_cycles=1.
//  4. Saturation: freeze for 20 cycles with CNT_W=4 -> stall_cycles reaches 15 and holds at 15.
//     It clears to 0 on the next load.
//  5. Flush and freeze together: flush=1, freeze=1 with mem_write_out=1
//     -> valid_out=0, mem_write_out=0, wb_en_out=0, stall_cycles=0.
//  6. Write-through on r0: src1=0, wb_wr_en=1, wb_dest=0, wb_value=0xFF, reg1=0 -> reg1_out=0.

Source files
------------

// File: rtl/idexe_pipe_reg.sv
// ID/EX pipeline register with hold, bubble insertion, a valid bit, write-back
// snooping of held operands and a saturating count of consecutive held cycles.
// Every output comes straight from a flop.
module idexe_pipe_reg #(
   parameter int LEN     = 32,
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5,
   parameter int CMD_W   = 4,
   parameter int CNT_W   = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               freeze,
   input  logic               flush,
   input  logic               valid_in,
   input  logic [LEN-1:0]     pc,
   input  logic [LEN-1:0]     instruction,
   input  logic               wb_en,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [1:0]         branch_type,
   input  logic [CMD_W-1:0]   exe_cmd,
   input  logic [RADDR_W-1:0] src1,
   input  logic [RADDR_W-1:0] src2,
   input  logic [DATA_W-1:0]  reg1,
   input  logic [DATA_W-1:0]  reg2,
   input  logic [DATA_W-1:0]  imm,
   input  logic [RADDR_W-1:0] dest,
   input  logic               wb_wr_en,
   input  logic [RADDR_W-1:0] wb_dest,
   input  logic [DATA_W-1:0]  wb_value,
   output logic [LEN-1:0]     pc_out,
   output logic [LEN-1:0]     instruction_out,
   output logic               wb_en_out,
   output logic               mem_read_out,
   output logic               mem_write_out,
   output logic [1:0]         branch_type_out,
   output logic [CMD_W-1:0]   exe_cmd_out,
   output logic [RADDR_W-1:0] src1_out,
   output logic [RADDR_W-1:0] src2_out,
   output logic [DATA_W-1:0]  reg1_out,
   output logic [DATA_W-1:0]  reg2_out,
   output logic [DATA_W-1:0]  imm_out,
   output logic [RADDR_W-1:0] dest_out,
   output logic               valid_out,
   output logic [CNT_W-1:0]   stall_cycles
);

   // r0 is hard-wired zero, so a write-back to it never forwards anywhere.
   logic wb_live;
   logic thru1, thru2;
   logic snoop1, snoop2;

   assign wb_live = wb_wr_en && (wb_dest != '0);
   assign thru1   = wb_live && (wb_dest == src1);
   assign thru2   = wb_live && (wb_dest == src2);
   assign snoop1  = valid_out && wb_live && (wb_dest == src1_out);
   assign snoop2  = valid_out && wb_live && (wb_dest == src2_out);

   // Stage register: reset, then flush beats freeze beats load.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_out          <= '0;
         instruction_out <= '0;
         wb_en_out       <= 1'b0;
         mem_read_out    <= 1'b0;
         mem_write_out   <= 1'b0;
         branch_type_out <= 2'b00;
         exe_cmd_out     <= '0;
         src1_out        <= '0;
         src2_out        <= '0;
         reg1_out        <= '0;
         reg2_out        <= '0;
         imm_out         <= '0;
         dest_out        <= '0;
         valid_out       <= 1'b0;
         stall_cycles    <= '0;
      end else if (flush) begin
         pc_out          <= '0;
         instruction_out <= '0;
         wb_en_out       <= 1'b0;
         mem_read_out    <= 1'b0;
         mem_write_out   <= 1'b0;
         branch_type_out <= 2'b00;
         exe_cmd_out     <= '0;
         src1_out        <= '0;
         src2_out        <= '0;
         reg1_out        <= '0;
         reg2_out        <= '0;
         imm_out         <= '0;
         dest_out        <= '0;
         valid_out       <= 1'b0;
         stall_cycles    <= '0;
      end else if (freeze) begin
         // Held instruction keeps everything except operands patched by WB.
         if (snoop1) reg1_out <= wb_value;
         if (snoop2) reg2_out <= wb_value;
         if (valid_out && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      end else begin
         pc_out          <= pc;
         instruction_out <= instruction;
         wb_en_out       <= wb_en & valid_in;
         mem_read_out    <= mem_read & valid_in;
         mem_write_out   <= mem_write & valid_in;
         branch_type_out <= valid_in ? branch_type : 2'b00;
         exe_cmd_out     <= exe_cmd;
         src1_out        <= src1;
         src2_out        <= src2;
         reg1_out        <= thru1 ? wb_value : reg1;
         reg2_out        <= thru2 ? wb_value : reg2;
         imm_out         <= imm;
         dest_out        <= dest;
         valid_out       <= valid_in;
         stall_cycles    <= '0;
      end
   end

endmodule

// File: tb/tb_idexe_pipe_reg.sv
// Directed plus short random bench for idexe_pipe_reg using an expected-state
// scoreboard fed by a behavioural model.
module tb_idexe_pipe_reg;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        freeze, flush, valid_in;
   logic [31:0] pc, instruction;
   logic        wb_en, mem_read, mem_write;
   logic [1:0]  branch_type;
   logic [3:0]  exe_cmd;
   logic [4:0]  src1, src2, dest, wb_dest;
   logic [31:0] reg1, reg2, imm, wb_value;
   logic        wb_wr_en;

   logic [31:0] pc_out, instruction_out, reg1_out, reg2_out, imm_out;
   logic        wb_en_out, mem_read_out, mem_write_out, valid_out;
   logic [1:0]  branch_type_out;
   logic [3:0]  exe_cmd_out, stall_cycles;
   logic [4:0]  src1_out, src2_out, dest_out;

   typedef struct packed {
      logic        freeze, flush, valid_in;
      logic [31:0] pc, instruction;
      logic        wb_en, mem_read, mem_write;
      logic [1:0]  branch_type;
      logic [3:0]  exe_cmd;
      logic [4:0]  src1, src2;
      logic [31:0] reg1, reg2, imm;
      logic [4:0]  dest;
      logic        wb_wr_en;
      logic [4:0]  wb_dest;
      logic [31:0] wb_value;
   } in_t;

   typedef struct packed {
      logic [31:0] pc, instruction;
      logic        wb_en, mem_read, mem_write;
      logic [1:0]  branch_type;
      logic [3:0]  exe_cmd;
      logic [4:0]  src1, src2;
      logic [31:0] reg1, reg2, imm;
      logic [4:0]  dest;
      logic        valid;
      logic [3:0]  stall;
   } st_t;

   st_t sb[$];
   st_t cur;
   int  passed = 0;
   int  total  = 0;

   idexe_pipe_reg dut (
      .clock(clock), .reset(reset), .freeze(freeze), .flush(flush), .valid_in(valid_in),
      .pc(pc), .instruction(instruction), .wb_en(wb_en), .mem_read(mem_read),
      .mem_write(mem_write), .branch_type(branch_type), .exe_cmd(exe_cmd),
      .src1(src1), .src2(src2), .reg1(reg1), .reg2(reg2), .imm(imm), .dest(dest),
      .wb_wr_en(wb_wr_en), .wb_dest(wb_dest), .wb_value(wb_value),
      .pc_out(pc_out), .instruction_out(instruction_out), .wb_en_out(wb_en_out),
      .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
      .branch_type_out(branch_type_out), .exe_cmd_out(exe_cmd_out),
      .src1_out(src1_out), .src2_out(src2_out), .reg1_out(reg1_out), .reg2_out(reg2_out),
      .imm_out(imm_out), .dest_out(dest_out), .valid_out(valid_out),
      .stall_cycles(stall_cycles)
   );

   always #5 clock = ~clock;

   // Reference behaviour of one clock edge.
   function automatic st_t model(st_t c, in_t s);
      st_t n;
      n = c;
      if (s.flush) begin
         n = '0;
      end else if (s.freeze) begin
         if (c.valid) begin
            if (s.wb_wr_en && s.wb_dest != 5'd0 && s.wb_dest == c.src1) n.reg1 = s.wb_value;
            if (s.wb_wr_en && s.wb_dest != 5'd0 && s.wb_dest == c.src2) n.reg2 = s.wb_value;
            n.stall = (c.stall == 4'd15) ? 4'd15 : c.stall + 4'd1;
         end
      end else begin
         n.pc          = s.pc;
         n.instruction = s.instruction;
         n.wb_en       = s.valid_in ? s.wb_en : 1'b0;
         n.mem_read    = s.valid_in ? s.mem_read : 1'b0;
         n.mem_write   = s.valid_in ? s.mem_write : 1'b0;
         n.branch_type = s.valid_in ? s.branch_type : 2'b00;
         n.exe_cmd     = s.exe_cmd;
         n.src1        = s.src1;
         n.src2        = s.src2;
         n.reg1        = (s.wb_wr_en && s.wb_dest != 5'd0 && s.wb_dest == s.src1) ? s.wb_value : s.reg1;
         n.reg2        = (s.wb_wr_en && s.wb_dest != 5'd0 && s.wb_dest == s.src2) ? s.wb_value : s.reg2;
         n.imm         = s.imm;
         n.dest        = s.dest;
         n.valid       = s.valid_in;
         n.stall       = 4'd0;
      end
      return n;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag, input st_t e);
      check({tag, ".pc"},          pc_out,          e.pc);
      check({tag, ".instruction"}, instruction_out, e.instruction);
      check({tag, ".wb_en"},       32'(wb_en_out),       32'(e.wb_en));
      check({tag, ".mem_read"},    32'(mem_read_out),    32'(e.mem_read));
      check({tag, ".mem_write"},   32'(mem_write_out),   32'(e.mem_write));
      check({tag, ".branch_type"}, 32'(branch_type_out), 32'(e.branch_type));
      check({tag, ".exe_cmd"},     32'(exe_cmd_out),     32'(e.exe_cmd));
      check({tag, ".src1"},        32'(src1_out),        32'(e.src1));
      check({tag, ".src2"},        32'(src2_out),        32'(e.src2));
      check({tag, ".reg1"},        reg1_out,        e.reg1);
      check({tag, ".reg2"},        reg2_out,        e.reg2);
      check({tag, ".imm"},         imm_out,         e.imm);
      check({tag, ".dest"},        32'(dest_out),        32'(e.dest));
      check({tag, ".valid"},       32'(valid_out),       32'(e.valid));
      check({tag, ".stall"},       32'(stall_cycles),    32'(e.stall));
   endtask

   // Drive one cycle of stimulus, push the expectation, then compare after the edge.
   task automatic step(input string tag, input in_t s);
      st_t e;
      freeze = s.freeze; flush = s.flush; valid_in = s.valid_in;
      pc = s.pc; instruction = s.instruction;
      wb_en = s.wb_en; mem_read = s.mem_read; mem_write = s.mem_write;
      branch_type = s.branch_type; exe_cmd = s.exe_cmd;
      src1 = s.src1; src2 = s.src2; reg1 = s.reg1; reg2 = s.reg2; imm = s.imm;
      dest = s.dest; wb_wr_en = s.wb_wr_en; wb_dest = s.wb_dest; wb_value = s.wb_value;
      cur = model(cur, s);
      sb.push_back(cur);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         check({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check_all(tag, e);
      end
   endtask

   function automatic in_t ld(input logic [31:0] p, input logic [4:0] s1, input logic [31:0] r1,
                              input logic [4:0] s2, input logic [31:0] r2, input logic [4:0] d);
      in_t s;
      s = '0;
      s.valid_in = 1'b1; s.pc = p; s.instruction = p ^ 32'hA5A5_0000;
      s.src1 = s1; s.reg1 = r1; s.src2 = s2; s.reg2 = r2; s.dest = d; s.imm = p + 32'd9;
      return s;
   endfunction

   initial begin
      in_t s;
      st_t z;
      z = '0;
      cur = '0;
      s = '0;
      {freeze, flush, valid_in, wb_en, mem_read, mem_write, wb_wr_en} = '0;
      {pc, instruction, reg1, reg2, imm, wb_value} = '0;
      {branch_type, exe_cmd, src1, src2, dest, wb_dest} = '0;
      #2;
      check_all("reset", z);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Basic load
      s = ld(32'h40, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
      s.exe_cmd = 4'h1; s.wb_en = 1'b1; s.branch_type = 2'b01;
      step("load", s);
      check("load.valid_lit", 32'(valid_out), 32'd1);
      check("load.pc_lit", pc_out, 32'h40);

      // Freeze with snoop on src1
      s = ld(32'h44, 5'd4, 32'h11, 5'd9, 32'h22, 5'd6);
      s.mem_write = 1'b1;
      step("load2", s);
      s = '0; s.freeze = 1'b1; s.wb_wr_en = 1'b1; s.wb_dest = 5'd4; s.wb_value = 32'hAB;
      s.pc = 32'hDEAD; s.valid_in = 1'b1;
      step("snoop", s);
      check("snoop.reg1_lit", reg1_out, 32'hAB);
      check("snoop.stall_lit", 32'(stall_cycles), 32'd1);

      // Saturation over 20 held cycles, then clear on load
      for (int i = 0; i < 20; i++) begin
         s = '0; s.freeze = 1'b1; s.wb_wr_en = 1'b1; s.wb_dest = 5'd9; s.wb_value = 32'(i);
         step("sat", s);
      end
      check("sat.stall_lit", 32'(stall_cycles), 32'd15);
      check("sat.reg2_lit", reg2_out, 32'd19);
      s = ld(32'h48, 5'd2, 32'd1, 5'd3, 32'd2, 5'd4);
      s.mem_write = 1'b1; s.wb_en = 1'b1;
      step("clear", s);
      check("clear.stall_lit", 32'(stall_cycles), 32'd0);

      // Flush wins over freeze
      s = '0; s.flush = 1'b1; s.freeze = 1'b1;
      step("flushfrz", s);
      check("flushfrz.mem_write_lit", 32'(mem_write_out), 32'd0);

      // Write-through: r0 ignored, both sources matching
      s = ld(32'h4C, 5'd0, 32'd0, 5'd8, 32'd3, 5'd1);
      s.wb_wr_en = 1'b1; s.wb_dest = 5'd0; s.wb_value = 32'hFF;
      step("thru_r0", s);
      check("thru_r0.reg1_lit", reg1_out, 32'd0);
      s = ld(32'h50, 5'd6, 32'd1, 5'd6, 32'd2, 5'd1);
      s.wb_wr_en = 1'b1; s.wb_dest = 5'd6; s.wb_value = 32'h77;
      step("thru_both", s);

      // Invalid instruction masks control bits; held bubble neither snoops nor counts
      s = ld(32'h54, 5'd5, 32'd1, 5'd7, 32'd2, 5'd1);
      s.valid_in = 1'b0; s.wb_en = 1'b1; s.mem_read = 1'b1; s.mem_write = 1'b1; s.branch_type = 2'b11;
      step("invalid", s);
      s = '0; s.freeze = 1'b1; s.wb_wr_en = 1'b1; s.wb_dest = 5'd5; s.wb_value = 32'h99;
      step("frz_invalid", s);
      check("frz_invalid.reg1_lit", reg1_out, 32'd1);

      // Random mix
      for (int i = 0; i < 200; i++) begin
         s = '0;
         s.flush = ($urandom_range(0, 9) == 0);
         s.freeze = ($urandom_range(0, 3) == 0);
         s.valid_in = ($urandom_range(0, 4) != 0);
         s.pc = $urandom; s.instruction = $urandom; s.imm = $urandom;
         s.wb_en = 1'($urandom); s.mem_read = 1'($urandom); s.mem_write = 1'($urandom);
         s.branch_type = 2'($urandom); s.exe_cmd = 4'($urandom);
         s.src1 = 5'($urandom_range(0, 3)); s.src2 = 5'($urandom_range(0, 3));
         s.reg1 = $urandom; s.reg2 = $urandom; s.dest = 5'($urandom);
         s.wb_wr_en = 1'($urandom); s.wb_dest = 5'($urandom_range(0, 3)); s.wb_value = $urandom;
         step("rand", s);
      end

      // Asynchronous reset mid-stream
      s = ld(32'h60, 5'd1, 32'd2, 5'd2, 32'd3, 5'd4);
      s.wb_en = 1'b1;
      step("pre_rst", s);
      check("pre_rst.valid_lit", 32'(valid_out), 32'd1);
      reset = 1'b1;
      #1;
      check_all("async_rst", z);
      cur = '0;
      #1;
      reset = 1'b0;
      s = ld(32'h64, 5'd1, 32'd8, 5'd2, 32'd9, 5'd5);
      step("post_rst", s);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
